// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates fetch and load/store accesses onto a single byte-wide RAM
// port, sequencing each 1/2/4-byte access as consecutive one-byte RAM cycles.
//
// state | meaning
// IDLE  | arbitrate sampled requests, latch the granted operands
// IF_RD | fetch word read: issue byte addresses, capture returning bytes
// LS_RD | load read: same sequencing as IF_RD for 1/2/4 bytes
// LS_WR | store: one byte per cycle, holds while the IO sink is full
// DONE  | completion pulse on the registered outputs, then back to IDLE
module mem_ctrl #(
    parameter logic [1:0] IO_HI = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_valid,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [3:0]  ls_sel,
    output logic        ls_ready,
    output logic [31:0] ls_rdata,
    input  logic        io_buffer_full,
    output logic [31:0] ram_a,
    output logic        ram_wr,
    output logic [7:0]  ram_dout,
    input  logic [7:0]  ram_din
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        IF_RD = 3'd1,
        LS_RD = 3'd2,
        LS_WR = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [1:0]  cnt;
    logic [1:0]  rcv;
    logic [2:0]  len;
    logic        last_ls;
    logic [31:0] base;
    logic [31:0] wdata;
    logic [31:0] asm_buf;
    logic        we;
    logic        iss_done;
    logic        cap_pend;
    logic        if_valid_q;
    logic        ls_ready_q;

    logic        grant_if;
    logic        grant_ls;
    logic        reading;
    logic        issuing;
    logic        capturing;
    logic        last_cap;
    logic        io_stall;
    logic [1:0]  len_m1;
    logic [2:0]  sel_len;
    logic [31:0] asm_next;

    // LSB wins a tie unless it was the last one served
    assign grant_ls  = !flush && ls_req && !(if_req && last_ls);
    assign grant_if  = !flush && if_req && !(ls_req && !last_ls);

    assign len_m1    = 2'(len - 3'd1);
    assign reading   = (state == IF_RD) || (state == LS_RD);
    assign issuing   = reading && !iss_done;
    assign capturing = reading && cap_pend;
    assign last_cap  = capturing && (rcv == len_m1);
    assign io_stall  = (state == LS_WR) && (base[17:16] == IO_HI) && io_buffer_full;

    always_comb begin
        case (ls_sel)
            4'b0001: sel_len = 3'd1;
            4'b0011: sel_len = 3'd2;
            default: sel_len = 3'd4;
        endcase
    end

    // ram_din carries the byte addressed in the previous cycle
    always_comb begin
        asm_next = asm_buf;
        if (capturing) begin
            asm_next[{rcv, 3'b000} +: 8] = ram_din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_ls) begin
                    state_next = ls_we ? LS_WR : LS_RD;
                end else if (grant_if) begin
                    state_next = IF_RD;
                end
            end
            IF_RD, LS_RD: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (last_cap) begin
                    state_next = DONE;
                end
            end
            LS_WR: begin
                if (!io_stall && (cnt == len_m1)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= 2'd0;
            rcv        <= 2'd0;
            len        <= 3'd0;
            last_ls    <= 1'b0;
            base       <= 32'd0;
            wdata      <= 32'd0;
            asm_buf    <= 32'd0;
            we         <= 1'b0;
            iss_done   <= 1'b0;
            cap_pend   <= 1'b0;
            if_valid_q <= 1'b0;
            ls_ready_q <= 1'b0;
            if_data    <= 32'd0;
            ls_rdata   <= 32'd0;
        end else begin
            if_valid_q <= 1'b0;
            ls_ready_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_ls || grant_if) begin
                        last_ls  <= grant_ls;
                        base     <= grant_ls ? ls_addr : if_addr;
                        wdata    <= ls_wdata;
                        len      <= grant_ls ? sel_len : 3'd4;
                        we       <= grant_ls && ls_we;
                        cnt      <= 2'd0;
                        rcv      <= 2'd0;
                        iss_done <= 1'b0;
                        cap_pend <= 1'b0;
                        asm_buf  <= 32'd0;
                    end
                end
                IF_RD, LS_RD: begin
                    cap_pend <= issuing;
                    if (issuing) begin
                        cnt <= cnt + 2'd1;
                        if (cnt == len_m1) begin
                            iss_done <= 1'b1;
                        end
                    end
                    if (capturing) begin
                        asm_buf <= asm_next;
                        rcv     <= rcv + 2'd1;
                    end
                    // the completion data is latched on the same edge as the last byte
                    if (last_cap && !flush) begin
                        if (state == IF_RD) begin
                            if_valid_q <= 1'b1;
                            if_data    <= asm_next;
                        end else begin
                            ls_ready_q <= 1'b1;
                            ls_rdata   <= asm_next;
                        end
                    end
                end
                LS_WR: begin
                    if (!io_stall) begin
                        cnt <= cnt + 2'd1;
                        if (cnt == len_m1) begin
                            ls_ready_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // a flush landing on the pulse cycle of a fetch or load kills the pulse
    always_comb begin
        ram_a    = 32'd0;
        ram_wr   = 1'b0;
        ram_dout = 8'd0;
        if (issuing) begin
            ram_a = base + {30'd0, cnt};
        end else if ((state == LS_WR) && !io_stall) begin
            ram_a    = base + {30'd0, cnt};
            ram_wr   = 1'b1;
            ram_dout = wdata[{cnt, 3'b000} +: 8];
        end
        if_valid = if_valid_q && !flush;
        ls_ready = ls_ready_q && !(flush && !we);
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed cycle-accurate checks plus randomized traffic, with
// completions checked by a queue scoreboard against a byte-array memory model.
`timescale 1ns/1ps
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_valid;
    logic [31:0] if_data;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [31:0] ls_addr = 32'd0;
    logic [31:0] ls_wdata = 32'd0;
    logic [3:0]  ls_sel = 4'b1111;
    logic        ls_ready;
    logic [31:0] ls_rdata;
    logic        io_buffer_full = 1'b0;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din = 8'd0;

    always #5 clk = ~clk;

    mem_ctrl #(.IO_HI(2'b11)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_data(if_data),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_sel(ls_sel), .ls_ready(ls_ready), .ls_rdata(ls_rdata),
        .io_buffer_full(io_buffer_full),
        .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int          kind;   // 0 fetch, 1 load, 2 store
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];

    logic [7:0] ram_mem [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A ^ {a[1:0], 6'd0};
    endfunction

    function automatic int nbytes(input logic [3:0] sel);
        case (sel)
            4'b0001: return 1;
            4'b0011: return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [3:0] sel);
        logic [31:0] d = 32'd0;
        for (int i = 0; i < nbytes(sel); i++) d[8*i +: 8] = ref_rd(a + 32'(i));
        return d;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [3:0] sel, input logic [31:0] wd);
        for (int i = 0; i < nbytes(sel); i++) ref_mem[a + 32'(i)] = wd[8*i +: 8];
    endtask

    // RAM model: the byte for this cycle's address appears on ram_din next cycle
    always @(posedge clk) begin
        ram_din <= ram_mem.exists(ram_a) ? ram_mem[ram_a] : init_byte(ram_a);
        if (ram_wr) ram_mem[ram_a] = ram_dout;
    end

    always @(posedge clk) begin
        if (rst && ram_wr)
            chk("io_write_while_full", {31'd0, (ram_a[17:16] == 2'b11) && io_buffer_full}, 32'd0);
    end

    // scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (if_valid) begin
            if (sb_q.size() == 0) begin
                chk("if_valid_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("if_order", e.kind, 0);
                chk("if_data", if_data, e.data);
            end
        end
        if (ls_ready) begin
            if (sb_q.size() == 0) begin
                chk("ls_ready_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("ls_order", {31'd0, e.kind != 0}, 32'd1);
                if (e.kind == 1) chk("ls_rdata", ls_rdata, e.data);
            end
        end
    end

    task automatic exp_if(input logic [31:0] a);
        exp_t e;
        e.kind = 0;
        e.data = ref_load(a, 4'b1111);
        sb_q.push_back(e);
    endtask

    task automatic exp_ls(input logic we, input logic [31:0] a, input logic [3:0] sel, input logic [31:0] wd);
        exp_t e;
        if (we) begin
            ref_store(a, sel, wd);
            e.kind = 2;
            e.data = 32'd0;
        end else begin
            e.kind = 1;
            e.data = ref_load(a, sel);
        end
        sb_q.push_back(e);
    endtask

    task automatic drive_if(input logic [31:0] a);
        if_req  = 1'b1;
        if_addr = a;
    endtask

    task automatic drive_ls(input logic we, input logic [31:0] a, input logic [3:0] sel, input logic [31:0] wd);
        ls_req   = 1'b1;
        ls_we    = we;
        ls_addr  = a;
        ls_sel   = sel;
        ls_wdata = wd;
    endtask

    task automatic wait_pulse(input bit want_if, input bit rand_io, input string tag);
        bit seen = 1'b0;
        for (int c = 0; c < 80 && !seen; c++) begin
            @(negedge clk);
            if (rand_io) io_buffer_full = ($urandom_range(0, 3) == 0);
            #1;
            if (want_if ? if_valid : ls_ready) begin
                seen = 1'b1;
                if (want_if) if_req = 1'b0;
                else ls_req = 1'b0;
            end
        end
        chk(tag, {31'd0, seen}, 32'd1);
        if (!seen) begin
            if_req = 1'b0;
            ls_req = 1'b0;
        end
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 7))
            0:       return 32'hFFFF_FFFC + $urandom_range(0, 3);
            1:       return 32'h0003_0000 + $urandom_range(0, 7);
            default: return 32'h0000_4000 + $urandom_range(0, 63);
        endcase
    endfunction

    initial begin
        logic [3:0]  sel_tab [3];
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  sel;
        sel_tab[0] = 4'b0001;
        sel_tab[1] = 4'b0011;
        sel_tab[2] = 4'b1111;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_ram_a", ram_a, 32'd0);
        chk("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
        chk("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_ls_ready", {31'd0, ls_ready}, 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_ls_rdata", ls_rdata, 32'd0);

        // contention from reset: LSB, then fetch, then LSB again
        @(negedge clk);
        rst = 1'b1;
        exp_ls(1'b1, 32'h100, 4'b1111, 32'h0000_0513);
        exp_if(32'h100);
        exp_ls(1'b1, 32'h2002, 4'b0011, 32'h0000_80FF);
        drive_ls(1'b1, 32'h100, 4'b1111, 32'h0000_0513);
        drive_if(32'h100);
        fork
            wait_pulse(1'b1, 1'b0, "ct_fetch_done");
            begin
                wait_pulse(1'b0, 1'b0, "ct_ls1_done");
                drive_ls(1'b1, 32'h2002, 4'b0011, 32'h0000_80FF);
                wait_pulse(1'b0, 1'b0, "ct_ls2_done");
            end
        join

        // word fetch timing
        @(negedge clk);
        exp_if(32'h100);
        drive_if(32'h100);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            #1;
            if (k <= 4) chk("wf_ram_a", ram_a, 32'h100 + 32'(k - 1));
            chk("wf_if_valid", {31'd0, if_valid}, {31'd0, k == 6});
            if (k == 6) chk("wf_if_data", if_data, 32'h0000_0513);
        end
        if_req = 1'b0;

        // half load
        @(negedge clk);
        exp_ls(1'b0, 32'h2002, 4'b0011, 32'd0);
        drive_ls(1'b0, 32'h2002, 4'b0011, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            #1;
            chk("hl_no_wr", {31'd0, ram_wr}, 32'd0);
            if (k <= 2) chk("hl_ram_a", ram_a, 32'h2002 + 32'(k - 1));
            chk("hl_ls_ready", {31'd0, ls_ready}, {31'd0, k == 4});
            if (k == 4) chk("hl_rdata", ls_rdata, 32'h0000_80FF);
        end
        ls_req = 1'b0;

        // byte store to IO with the sink full in cycles 1..3
        @(negedge clk);
        io_buffer_full = 1'b1;
        exp_ls(1'b1, 32'h30000, 4'b0001, 32'h41);
        drive_ls(1'b1, 32'h30000, 4'b0001, 32'h41);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            io_buffer_full = (k <= 3);
            #1;
            if (k <= 3) chk("io_stall_wr", {31'd0, ram_wr}, 32'd0);
            if (k == 4) begin
                chk("io_wr", {31'd0, ram_wr}, 32'd1);
                chk("io_dout", {24'd0, ram_dout}, 32'h41);
                chk("io_ram_a", ram_a, 32'h30000);
            end
            chk("io_ls_ready", {31'd0, ls_ready}, {31'd0, k == 5});
        end
        ls_req = 1'b0;

        // flush in cycle 3 of a fetch, new fetch in cycle 4
        @(negedge clk);
        drive_if(32'h100);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 3) flush = 1'b1;
            if (k == 4) begin
                flush = 1'b0;
                exp_if(32'h200);
                drive_if(32'h200);
            end
            #1;
            if (k >= 3) chk("fl_if_valid", {31'd0, if_valid}, {31'd0, k == 10});
        end
        if_req = 1'b0;

        // reset in cycle 2 of a word store
        @(negedge clk);
        drive_ls(1'b1, 32'h3000, 4'b1111, 32'hDEAD_BEEF);
        @(negedge clk);
        #1;
        chk("rs_first_wr", {31'd0, ram_wr}, 32'd1);
        ref_mem[32'h3000] = 8'hEF;
        @(negedge clk);
        rst = 1'b0;
        ls_req = 1'b0;
        #1;
        chk("rs_ram_wr", {31'd0, ram_wr}, 32'd0);
        chk("rs_ram_a", ram_a, 32'd0);
        chk("rs_ram_dout", {24'd0, ram_dout}, 32'd0);
        chk("rs_ls_ready", {31'd0, ls_ready}, 32'd0);
        chk("rs_if_data", if_data, 32'd0);
        chk("rs_ls_rdata", ls_rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            chk("rs_after_wr", {31'd0, ram_wr}, 32'd0);
            chk("rs_after_ready", {31'd0, ls_ready}, 32'd0);
        end

        // randomized traffic, one requester at a time
        for (int t = 0; t < 150; t++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            @(negedge clk);
            case ($urandom_range(0, 9))
                0, 1, 2: begin
                    a = 32'h4000 + 4 * $urandom_range(0, 15);
                    exp_if(a);
                    drive_if(a);
                    wait_pulse(1'b1, 1'b1, "rnd_fetch_done");
                end
                default: begin
                    a   = pick_addr();
                    sel = sel_tab[$urandom_range(0, 2)];
                    wd  = $urandom;
                    if ($urandom_range(0, 1) == 0) begin
                        exp_ls(1'b0, a, sel, 32'd0);
                        drive_ls(1'b0, a, sel, 32'd0);
                    end else begin
                        exp_ls(1'b1, a, sel, wd);
                        drive_ls(1'b1, a, sel, wd);
                    end
                    wait_pulse(1'b0, 1'b1, "rnd_ls_done");
                end
            endcase
        end
        io_buffer_full = 1'b0;

        repeat (4) @(negedge clk);
        chk("sb_drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
